display_bcd_converter: RTL and testbench
========================================

# display_bcd_converter

Sequential binary-to-BCD converter that sits between the CPU's 32-bit `display` output and the eight hex digit drivers. It lets the seven-segment displays show the CPU result in decimal. It accepts one unsigned binary word per handshake and runs an iterative shift-and-add-3 (double-dabble) loop at one input bit per cycle. It then presents DIGITS packed BCD nibbles, plus an overflow flag for values that do not fit in DIGITS decimal digits.

## Interface
- WIDTH, 32: width of the binary input; must be ≥ 4.
- DIGITS, 8: number of BCD output digits; bcd width is 4*DIGITS.

- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  bin is valid this cycle.
- in_ready  output  1  converter can accept a word; high only in IDLE with rst_n high.
- bin  input  WIDTH  unsigned binary value; sampled on the accept edge only.
- out_valid  output  1  bcd/overflow hold a completed result; registered.
- out_ready  input  1  consumer takes the result.
- bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]; equals bin mod 10^DIGITS; registered.
- overflow  output  1  bin ≥ 10^DIGITS; registered, qualified by out_valid.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready. On accept: latch bin into the shift register, clear the BCD scratch to 0, clear sticky ovf to 0, load cnt=WIDTH-1, go to SHIFT.
- SHIFT, once per cycle:
  1. Every scratch nibble ≥ 5 gets +3 (4-bit, no carry between nibbles).
  2. Shift {scratch, binreg} left by one.
  3. The bit shifted out of scratch's MSB ORs into sticky ovf.
  - If cnt==0, go to DONE and copy scratch→bcd and ovf→overflow in the same edge. Otherwise decrement cnt.
- DONE:
  - out_valid=1.
  - bcd and overflow are held stable.
  - When out_ready=1, go to IDLE and drop out_valid.
- in_valid is ignored outside IDLE. A new word is never accepted in the same cycle a result is consumed.
- bcd/overflow keep the last result after leaving DONE, until the next DONE entry.
- Reset values: state IDLE, in_ready=0 while rst_n low, out_valid=0, bcd=0, overflow=0, cnt=0. Scratch and binreg are cleared.
- Reset mid-SHIFT or mid-DONE aborts the conversion. No partial result is ever presented.

## Timing
- Accept edge = edge A. WIDTH shift edges follow (A+1 … A+WIDTH).
- out_valid is high from the edge after A+WIDTH.
- Latency from the accept cycle to the first out_valid cycle is WIDTH+1 cycles: 33 for WIDTH=32.
- If out_ready is already high, DONE lasts one cycle and in_ready returns the following cycle.
- Minimum accept-to-accept spacing is WIDTH+2 cycles.
- in_ready is combinational from state only; no combinational path from in_valid or out_ready to any output.

## Structure
- Package display_pkg: state enum typedef (IDLE/SHIFT/DONE) and BCD_ADJ_THRESH=4'd5 / BCD_ADJ_ADD=4'd3 constants.
- Sub-module bcd_digit_adjust: combinational 4-bit nibble, output nibble+3 if ≥5, else unchanged. Instantiated DIGITS times via generate.
- The top holds the FSM, the counter ($clog2(WIDTH) bits), the shift registers and the output registers.

## Test plan
- bin=0 → bcd=32'h00000000, overflow=0; out_valid first high 33 cycles after the accept cycle (WIDTH=32).
- bin=12345678 → bcd=32'h12345678, overflow=0; bin=99999999 → bcd=32'h99999999, overflow=0.
- bin=100000000 → bcd=32'h00000000, overflow=1; bin=32'hFFFFFFFF → bcd=32'h94967295, overflow=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid while in_valid=1 with a new bin. bcd stays stable, in_ready=0, and no accept occurs. Raise out_ready, then in_ready=1 the next cycle and the new word converts correctly.
- Reset mid-conversion: assert rst_n=0 for one edge at shift 10 of bin=87654321. Required next cycle: out_valid=0, bcd=0, overflow=0, state IDLE. A following conversion of 42 gives bcd=32'h00000042.
- Back-to-back: drive 500 random words with random out_ready stalls. Every result must match a reference model of bin mod 10^8 and bin ≥ 10^8, with in-order, one-to-one transfers.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display binary-to-BCD converter.
package display_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Double-dabble nibble correction: a digit of 5 or more is bumped by 3
  // before the shift so that doubling carries correctly into the next digit.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage : display_pkg

// File: rtl/bcd_digit_adjust.sv
// Single-digit add-3 correction used by the double-dabble loop.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Digits 0..9 map to at most 12, so the 4-bit sum never wraps.
  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;

endmodule : bcd_digit_adjust

// File: rtl/display_bcd_converter.sv
// Iterative binary-to-BCD converter feeding the seven-segment digit drivers.
// One input bit is consumed per cycle; the result is held until taken.
module display_bcd_converter
  import display_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [WIDTH-1:0]     binreg_q,    binreg_d;
  logic [BCD_W-1:0]     scratch_q,   scratch_d;
  logic                 ovf_q,       ovf_d;
  logic [BCD_W-1:0]     bcd_q,       bcd_d;
  logic                 overflow_q,  overflow_d;
  logic                 out_valid_q, out_valid_d;

  logic [BCD_W-1:0]     scratch_adj;
  logic [BCD_W-1:0]     scratch_shift;
  logic [WIDTH-1:0]     binreg_shift;
  logic                 ovf_next;

  // Per-digit add-3 correction of the current scratch value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  // One double-dabble step: shift {scratch, binreg} left and catch the carry
  // leaving the top digit, which means the value needs more than DIGITS digits.
  always_comb begin
    scratch_shift = {scratch_adj[BCD_W-2:0], binreg_q[WIDTH-1]};
    binreg_shift  = {binreg_q[WIDTH-2:0], 1'b0};
    ovf_next      = ovf_q | scratch_adj[BCD_W-1];
  end

  // Ready depends only on state and reset, never on in_valid or out_ready.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign overflow  = overflow_q;

  // Next-state and datapath update for the accept / shift / hold sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    binreg_d    = binreg_q;
    scratch_d   = scratch_q;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          binreg_d  = bin;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_shift;
        binreg_d  = binreg_shift;
        ovf_d     = ovf_next;
        if (cnt_q == '0) begin
          // Publish the finished value on the same edge as the last shift.
          bcd_d       = scratch_shift;
          overflow_d  = ovf_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset is sampled on the clock edge and
  // discards any conversion in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every register see the pre-edge
    // value of the others, which is what the shift chain relies on.
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      binreg_q    <= '0;
      scratch_q   <= '0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      binreg_q    <= binreg_d;
      scratch_q   <= scratch_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule : display_bcd_converter

// File: tb/tb_display_bcd_converter.sv
// Scoreboard bench for display_bcd_converter: the driver queues expected
// results on accept, an independent monitor compares them on each transfer.
module tb_display_bcd_converter;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] bcd;
  logic        overflow;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: held off

  display_bcd_converter #(.WIDTH(32), .DIGITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits of bin mod 10^8, overflow when bin >= 10^8.
  function automatic exp_t model(input logic [31:0] b);
    exp_t           m;
    longint unsigned v;
    v     = longint'(b);
    m.ovf = (v >= 64'd100000000);
    v     = v % 64'd100000000;
    m.bcd = '0;
    for (int i = 0; i < 8; i++) begin
      m.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return m;
  endfunction

  // Consumer-side ready pattern, driven just after each active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      2:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: any presented result must be expected; a transfer pops and compares.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out: got bcd %0h with empty scoreboard at %0t", bcd, $time);
      end else if (out_ready) begin
        exp_t e;
        e = sb_q.pop_front();
        check("bcd", 64'(bcd), 64'(e.bcd));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  // Offer one word and wait (bounded) for its accept; optionally queue the expectation.
  task automatic send(input logic [31:0] b, input bit push, input logic [31:0] e_bcd,
                      input logic e_ovf);
    int   waitc;
    exp_t e;
    waitc = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    bin      = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waitc++;
      if (waitc > 300) begin
        $display("FAIL accept_timeout: got no in_ready expected accept of %0h", b);
        $fatal(1, "accept timeout");
      end
    end
    if (push) begin
      e.bcd = e_bcd;
      e.ovf = e_ovf;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin      = $urandom;
  endtask

  // Wait (bounded) until every queued result has been taken.
  task automatic drain();
    int waitc;
    waitc = 0;
    while (sb_q.size() != 0 && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   waitc;
    exp_t m;
    logic [31:0] r;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    bin      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Zero, with accept-to-first-valid latency measured in cycles.
    send(32'd0, 1'b1, 32'h00000000, 1'b0);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd33);
    drain();

    // Directed values, including both sides of the 10^8 boundary.
    send(32'd12345678,  1'b1, 32'h12345678, 1'b0);
    send(32'd99999999,  1'b1, 32'h99999999, 1'b0);
    send(32'd100000000, 1'b1, 32'h00000000, 1'b1);
    send(32'hFFFFFFFF,  1'b1, 32'h94967295, 1'b1);
    send(32'd10,        1'b1, 32'h00000010, 1'b0);
    drain();

    // Reset at the tenth shift edge aborts the conversion entirely.
    send(32'd87654321, 1'b0, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    check("abort_idle", 64'(in_ready), 64'd1);
    send(32'd42, 1'b1, 32'h00000042, 1'b0);
    drain();

    // Backpressure: result held, new word offered but refused until taken.
    rdy_mode = 2;
    send(32'd31415926, 1'b1, 32'h31415926, 1'b0);
    waitc = 0;
    while (!out_valid && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    bin      = 32'd271828;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_bcd_hold", 64'(bcd), 64'h31415926);
    end
    rdy_mode = 0;
    @(negedge clk);
    check("bp_take_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_after_in_ready", 64'(in_ready), 64'd1);
    m.bcd = 32'h00271828;
    m.ovf = 1'b0;
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check("bp_bcd_after", 64'(bcd), 64'h00271828);

    // Random words with random consumer stalls.
    rdy_mode = 1;
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       r = $urandom_range(0, 99999999);
        1:       r = 32'd99999990 + $urandom_range(0, 20);
        default: r = $urandom;
      endcase
      m = model(r);
      send(r, 1'b1, m.bcd, m.ovf);
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_display_bcd_converter
